// File: rtl/store_drain_unit_pkg.sv
// Shared definitions for the store drain unit.
//   drain_state_e : FSM state encoding
//   mat_e         : memory access type encodings seen on SbToDcdAMat
//   bus_resp_e    : write response encodings seen on BusBResp
package store_drain_unit_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StCwr  = 3'd1,
        StBaw  = 3'd2,
        StBrsp = 3'd3,
        StBack = 3'd4
    } drain_state_e;

    // Only MAT_CC selects the cached path; every other code drains to the bus.
    typedef enum logic [1:0] {
        MAT_SUC = 2'b00,
        MAT_CC  = 2'b01
    } mat_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } bus_resp_e;

endpackage

// File: rtl/drain_watchdog.sv
// Bus write-response watchdog.
//   Clk    : clock, rising edge
//   Rest   : asynchronous active-high reset
//   clear  : restart the count from zero (takes priority over enable)
//   enable : count one waiting cycle
//   expire : count has reached all-ones
module drain_watchdog #(
    parameter int unsigned TMO_W = 8
) (
    input  logic Clk,
    input  logic Rest,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [TMO_W-1:0] cnt_q, cnt_d;

    assign expire = &cnt_q;

    // Saturate at all-ones so a stalled enable cannot wrap back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expire) begin
            cnt_d = cnt_q + TMO_W'(1);
        end
    end

    always_ff @(posedge Clk or posedge Rest) begin
        if (Rest) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/store_drain_unit.sv
// Store drain unit: takes one retired store at a time from the store buffer and
// writes it either to the D-cache data port (cached MAT) or to the bus (uncached),
// then reports completion of that store-buffer entry with a one-cycle pulse.
//   Clk, Rest            : clock, asynchronous active-high reset
//   SbToDcdA*            : store request from the store buffer
//   DcdToSbSuccess       : request accepted this cycle
//   DcdToSbBackAble/Ptr  : completion pulse and entry index
//   DcWr*                : cached write request / payload / ack
//   BusAw*, BusW*, BusB* : uncached address+data and write-response handshakes
//   DrainErr             : pulse on bus error response or response timeout
module store_drain_unit
    import store_drain_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TMO_W  = 8
) (
    input  logic              Clk,
    input  logic              Rest,
    input  logic              SbToDcdAble,
    input  logic [1:0]        SbToDcdAMat,
    input  logic [2:0]        SbToDcdAPtr,
    input  logic [ADDR_W-1:0] SbToDcdAPhyAddr,
    input  logic [DATA_W-1:0] SbToDcdAPhyDate,
    input  logic [3:0]        SbToDcdAWstrb,
    output logic              DcdToSbSuccess,
    output logic              DcdToSbBackAble,
    output logic [2:0]        DcdToSbBackPtr,
    output logic              DcWrReq,
    output logic [ADDR_W-1:0] DcWrAddr,
    output logic [DATA_W-1:0] DcWrData,
    output logic [3:0]        DcWrStrb,
    input  logic              DcWrAck,
    output logic              BusAwValid,
    input  logic              BusAwReady,
    output logic [ADDR_W-1:0] BusAddr,
    output logic [DATA_W-1:0] BusWData,
    output logic [3:0]        BusWStrb,
    input  logic              BusBValid,
    output logic              BusBReady,
    input  logic [1:0]        BusBResp,
    output logic              DrainErr
);

    drain_state_e      state_q, state_d;
    logic              accept;
    logic [2:0]        ptr_q;
    logic [1:0]        mat_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [3:0]        strb_q;
    logic              wdg_clear, wdg_enable, wdg_expire;

    assign accept = SbToDcdAble && (state_q == StIdle);

    // Count restarts on the AW handshake so the first BRSP cycle sees zero.
    assign wdg_clear  = (state_q == StBaw) && BusAwReady;
    assign wdg_enable = (state_q == StBrsp) && !BusBValid;

    drain_watchdog #(
        .TMO_W (TMO_W)
    ) u_watchdog (
        .Clk    (Clk),
        .Rest   (Rest),
        .clear  (wdg_clear),
        .enable (wdg_enable),
        .expire (wdg_expire)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (SbToDcdAble) begin
                    state_d = (SbToDcdAMat == MAT_CC) ? StCwr : StBaw;
                end
            end
            StCwr: begin
                if (DcWrAck) state_d = StBack;
            end
            StBaw: begin
                if (BusAwReady) state_d = StBrsp;
            end
            StBrsp: begin
                if (BusBValid || wdg_expire) state_d = StBack;
            end
            StBack: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rest) begin
        if (Rest) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Request fields are captured once at acceptance; the store buffer may
    // change its inputs freely while the store is draining.
    always_ff @(posedge Clk or posedge Rest) begin
        if (Rest) begin
            ptr_q  <= '0;
            mat_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
            strb_q <= '0;
        end else if (accept) begin
            ptr_q  <= SbToDcdAPtr;
            mat_q  <= SbToDcdAMat;
            addr_q <= SbToDcdAPhyAddr;
            data_q <= SbToDcdAPhyDate;
            strb_q <= SbToDcdAWstrb;
        end
    end

    always_comb begin
        DcdToSbSuccess  = accept;
        // The latched MAT qualifies which port the store may appear on.
        DcWrReq         = (state_q == StCwr) && (mat_q == MAT_CC);
        BusAwValid      = (state_q == StBaw) && (mat_q != MAT_CC);
        BusBReady       = (state_q == StBrsp);
        DcdToSbBackAble = (state_q == StBack);
        DcdToSbBackPtr  = (state_q == StBack) ? ptr_q : 3'd0;
        DrainErr        = 1'b0;
        if (state_q == StBrsp) begin
            // A real response wins over a coincident watchdog expiry.
            DrainErr = BusBValid ? (BusBResp != RESP_OKAY) : wdg_expire;
        end
        DcWrAddr = addr_q;
        DcWrData = data_q;
        DcWrStrb = strb_q;
        BusAddr  = addr_q;
        BusWData = data_q;
        BusWStrb = strb_q;
    end

endmodule

// File: tb/tb_store_drain_unit.sv
module tb_store_drain_unit;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int TMO_W  = 8;
    localparam int TMO_LAST = (1 << TMO_W) - 1;

    logic              Clk = 1'b0;
    logic              Rest;
    logic              SbToDcdAble;
    logic [1:0]        SbToDcdAMat;
    logic [2:0]        SbToDcdAPtr;
    logic [ADDR_W-1:0] SbToDcdAPhyAddr;
    logic [DATA_W-1:0] SbToDcdAPhyDate;
    logic [3:0]        SbToDcdAWstrb;
    logic              DcdToSbSuccess;
    logic              DcdToSbBackAble;
    logic [2:0]        DcdToSbBackPtr;
    logic              DcWrReq;
    logic [ADDR_W-1:0] DcWrAddr;
    logic [DATA_W-1:0] DcWrData;
    logic [3:0]        DcWrStrb;
    logic              DcWrAck;
    logic              BusAwValid;
    logic              BusAwReady;
    logic [ADDR_W-1:0] BusAddr;
    logic [DATA_W-1:0] BusWData;
    logic [3:0]        BusWStrb;
    logic              BusBValid;
    logic              BusBReady;
    logic [1:0]        BusBResp;
    logic              DrainErr;

    store_drain_unit #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TMO_W  (TMO_W)
    ) dut (
        .Clk             (Clk),
        .Rest            (Rest),
        .SbToDcdAble     (SbToDcdAble),
        .SbToDcdAMat     (SbToDcdAMat),
        .SbToDcdAPtr     (SbToDcdAPtr),
        .SbToDcdAPhyAddr (SbToDcdAPhyAddr),
        .SbToDcdAPhyDate (SbToDcdAPhyDate),
        .SbToDcdAWstrb   (SbToDcdAWstrb),
        .DcdToSbSuccess  (DcdToSbSuccess),
        .DcdToSbBackAble (DcdToSbBackAble),
        .DcdToSbBackPtr  (DcdToSbBackPtr),
        .DcWrReq         (DcWrReq),
        .DcWrAddr        (DcWrAddr),
        .DcWrData        (DcWrData),
        .DcWrStrb        (DcWrStrb),
        .DcWrAck         (DcWrAck),
        .BusAwValid      (BusAwValid),
        .BusAwReady      (BusAwReady),
        .BusAddr         (BusAddr),
        .BusWData        (BusWData),
        .BusWStrb        (BusWStrb),
        .BusBValid       (BusBValid),
        .BusBReady       (BusBReady),
        .BusBResp        (BusBResp),
        .DrainErr        (DrainErr)
    );

    always #5 Clk = ~Clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // {Success, DcWrReq, BusAwValid, BusBReady, BackAble, DrainErr}
    logic [5:0] ctl;
    assign ctl = {DcdToSbSuccess, DcWrReq, BusAwValid, BusBReady, DcdToSbBackAble, DrainErr};

    // Observation log: acceptance cycle numbers and completed pointers, in order.
    int cyc = 0;
    int acc_cyc[$];
    int back_ptr[$];
    always @(negedge Clk) begin
        cyc++;
        if (DcdToSbSuccess === 1'b1) acc_cyc.push_back(cyc);
        if (DcdToSbBackAble === 1'b1) back_ptr.push_back(int'(DcdToSbBackPtr));
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic scramble_req();
        SbToDcdAMat     = 2'($urandom);
        SbToDcdAPtr     = 3'($urandom);
        SbToDcdAPhyAddr = $urandom;
        SbToDcdAPhyDate = $urandom;
        SbToDcdAWstrb   = 4'($urandom);
    endtask

    task automatic idle_inputs();
        SbToDcdAble = 1'b0;
        DcWrAck     = 1'b0;
        BusAwReady  = 1'b0;
        BusBValid   = 1'b0;
        BusBResp    = 2'b00;
    endtask

    // Drives one store from acceptance to completion, predicting every cycle from
    // the transaction parameters: cached stores sit in the D-cache phase for dly+1
    // cycles; uncached ones present AW for dly+1 cycles, then wait bdly+1 cycles for
    // the response (or TMO_LAST+1 cycles when it never arrives), then one BACK cycle.
    // Starts and ends at posedge+1 of an idle cycle.
    task automatic do_store(input string tag, input logic [1:0] mat, input logic [2:0] ptr,
                            input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                            input logic [3:0] strb, input int dly, input int bdly,
                            input logic [1:0] bresp, input bit no_b, input bit hold_able);
        bit         cached;
        int         limit;
        logic [5:0] want;
        cached = (mat == 2'b01);
        idle_inputs();
        SbToDcdAble     = 1'b1;
        SbToDcdAMat     = mat;
        SbToDcdAPtr     = ptr;
        SbToDcdAPhyAddr = addr;
        SbToDcdAPhyDate = data;
        SbToDcdAWstrb   = strb;
        @(negedge Clk);
        tests_run++;
        if (ctl !== 6'b100000 || DcdToSbBackPtr !== 3'd0) begin
            tests_failed++;
            $display("FAIL %s accept: ctl=%b backptr=%0d want ctl=100000 backptr=0",
                     tag, ctl, DcdToSbBackPtr);
        end
        step();
        if (cached) begin
            for (int i = 0; i <= dly; i++) begin
                SbToDcdAble = hold_able ? 1'b1 : 1'($urandom);
                scramble_req();
                DcWrAck    = (i == dly);
                BusAwReady = 1'($urandom);
                BusBValid  = 1'($urandom);
                BusBResp   = 2'($urandom);
                @(negedge Clk);
                tests_run++;
                if (ctl !== 6'b010000 || DcWrAddr !== addr || DcWrData !== data ||
                    DcWrStrb !== strb) begin
                    tests_failed++;
                    $display("FAIL %s cwr[%0d]: ctl=%b addr=%h data=%h strb=%h want ctl=010000 addr=%h data=%h strb=%h",
                             tag, i, ctl, DcWrAddr, DcWrData, DcWrStrb, addr, data, strb);
                end
                step();
            end
        end else begin
            for (int i = 0; i <= dly; i++) begin
                SbToDcdAble = hold_able ? 1'b1 : 1'($urandom);
                scramble_req();
                DcWrAck    = 1'($urandom);
                BusAwReady = (i == dly);
                BusBValid  = 1'($urandom);
                BusBResp   = 2'($urandom);
                @(negedge Clk);
                tests_run++;
                if (ctl !== 6'b001000 || BusAddr !== addr || BusWData !== data ||
                    BusWStrb !== strb) begin
                    tests_failed++;
                    $display("FAIL %s baw[%0d]: ctl=%b addr=%h data=%h strb=%h want ctl=001000 addr=%h data=%h strb=%h",
                             tag, i, ctl, BusAddr, BusWData, BusWStrb, addr, data, strb);
                end
                step();
            end
            limit = no_b ? TMO_LAST : bdly;
            for (int j = 0; j <= limit; j++) begin
                SbToDcdAble = hold_able ? 1'b1 : 1'($urandom);
                scramble_req();
                DcWrAck    = 1'($urandom);
                BusAwReady = 1'($urandom);
                BusBValid  = !no_b && (j == limit);
                BusBResp   = (j == limit) ? bresp : 2'($urandom);
                want = 6'b000100;
                if (j == limit && (no_b || bresp != 2'b00)) want[0] = 1'b1;
                @(negedge Clk);
                tests_run++;
                if (ctl !== want) begin
                    tests_failed++;
                    $display("FAIL %s brsp[%0d]: ctl=%b want %b", tag, j, ctl, want);
                end
                step();
            end
        end
        SbToDcdAble = hold_able ? 1'b1 : 1'($urandom);
        scramble_req();
        DcWrAck    = 1'($urandom);
        BusAwReady = 1'($urandom);
        BusBValid  = 1'($urandom);
        BusBResp   = 2'($urandom);
        @(negedge Clk);
        tests_run++;
        if (ctl !== 6'b000010 || DcdToSbBackPtr !== ptr) begin
            tests_failed++;
            $display("FAIL %s back: ctl=%b backptr=%0d want ctl=000010 backptr=%0d",
                     tag, ctl, DcdToSbBackPtr, ptr);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_reset();
        Rest = 1'b1;
        idle_inputs();
        scramble_req();
        #1;
        tests_run++;
        if (ctl !== 6'b0 || DcdToSbBackPtr !== 3'd0 || DcWrAddr !== '0 || DcWrData !== '0 ||
            DcWrStrb !== 4'd0 || BusAddr !== '0 || BusWData !== '0 || BusWStrb !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: ctl=%b backptr=%0d dcaddr=%h busaddr=%h want all zero",
                     ctl, DcdToSbBackPtr, DcWrAddr, BusAddr);
        end
        repeat (2) step();
        Rest = 1'b0;
        step();
        @(negedge Clk);
        tests_run++;
        if (ctl !== 6'b0 || DcdToSbBackPtr !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_idle: ctl=%b backptr=%0d want ctl=000000 backptr=0",
                     ctl, DcdToSbBackPtr);
        end
        step();
    endtask

    task automatic test_cached();
        do_store("cached", 2'b01, 3'd3, 32'h1000_0040, 32'hDEAD_BEEF, 4'hF, 1, 0, 2'b00, 0, 0);
    endtask

    task automatic test_uncached();
        do_store("uncached", 2'b00, 3'd5, 32'h2000_0104, 32'h0000_00A5, 4'h1, 4, 0, 2'b00, 0, 0);
    endtask

    task automatic test_error_resp();
        do_store("err_resp", 2'b10, 3'd4, 32'h3000_0008, 32'h1234_5678, 4'h3, 1, 2, 2'b10, 0, 0);
        do_store("after_err", 2'b01, 3'd6, 32'h0000_0010, 32'hCAFE_F00D, 4'hC, 0, 0, 2'b00, 0, 0);
    endtask

    task automatic test_timeout();
        do_store("timeout", 2'b11, 3'd7, 32'h4000_0000, 32'h5555_AAAA, 4'hF, 0, 0, 2'b00, 1, 0);
        do_store("after_tmo", 2'b01, 3'd2, 32'h0000_0020, 32'h0BAD_F00D, 4'h6, 0, 0, 2'b00, 0, 0);
    endtask

    task automatic test_back_to_back();
        int n_acc, n_back;
        acc_cyc.delete();
        back_ptr.delete();
        do_store("b2b_1", 2'b01, 3'd1, 32'h0000_1000, 32'h1111_1111, 4'hF, 0, 0, 2'b00, 0, 1);
        do_store("b2b_2", 2'b01, 3'd2, 32'h0000_1004, 32'h2222_2222, 4'hF, 0, 0, 2'b00, 0, 1);
        n_acc  = acc_cyc.size();
        n_back = back_ptr.size();
        tests_run++;
        if (n_acc != 2 || (acc_cyc[1] - acc_cyc[0]) != 3) begin
            tests_failed++;
            $display("FAIL b2b_spacing: accepts=%0d gap=%0d want accepts=2 gap=3",
                     n_acc, (n_acc == 2) ? acc_cyc[1] - acc_cyc[0] : -1);
        end
        tests_run++;
        if (n_back != 2 || back_ptr[0] != 1 || back_ptr[1] != 2) begin
            tests_failed++;
            $display("FAIL b2b_order: count=%0d first=%0d second=%0d want count=2 first=1 second=2",
                     n_back, (n_back > 0) ? back_ptr[0] : -1, (n_back > 1) ? back_ptr[1] : -1);
        end
    endtask

    task automatic test_ptr_zero();
        do_store("ptr0_unc", 2'b00, 3'd0, 32'h0000_0300, 32'h7777_0000, 4'h8, 0, 1, 2'b00, 0, 0);
        do_store("ptr0_cc", 2'b01, 3'd0, 32'h0000_0304, 32'h0000_7777, 4'h1, 2, 0, 2'b00, 0, 0);
    endtask

    task automatic test_reset_in_baw();
        idle_inputs();
        SbToDcdAble     = 1'b1;
        SbToDcdAMat     = 2'b00;
        SbToDcdAPtr     = 3'd6;
        SbToDcdAPhyAddr = 32'h5000_0000;
        SbToDcdAPhyDate = 32'h9999_9999;
        SbToDcdAWstrb   = 4'hF;
        step();
        SbToDcdAble = 1'b0;
        repeat (2) step();
        @(negedge Clk);
        tests_run++;
        if (ctl !== 6'b001000 || BusAddr !== 32'h5000_0000) begin
            tests_failed++;
            $display("FAIL rst_baw_pre: ctl=%b addr=%h want ctl=001000 addr=50000000",
                     ctl, BusAddr);
        end
        #2;
        Rest = 1'b1;
        #1;
        tests_run++;
        if (ctl !== 6'b0 || DcdToSbBackPtr !== 3'd0 || BusAddr !== '0 || BusWData !== '0 ||
            BusWStrb !== 4'd0) begin
            tests_failed++;
            $display("FAIL rst_baw_async: ctl=%b backptr=%0d addr=%h data=%h strb=%h want all zero",
                     ctl, DcdToSbBackPtr, BusAddr, BusWData, BusWStrb);
        end
        step();
        Rest = 1'b0;
        for (int i = 0; i < 3; i++) begin
            BusAwReady = 1'($urandom);
            BusBValid  = 1'($urandom);
            @(negedge Clk);
            tests_run++;
            if (ctl !== 6'b0) begin
                tests_failed++;
                $display("FAIL rst_baw_quiet[%0d]: ctl=%b want 000000", i, ctl);
            end
            step();
        end
        idle_inputs();
        do_store("after_rst", 2'b00, 3'd1, 32'h5000_0010, 32'h8888_8888, 4'h5, 1, 1, 2'b00, 0, 0);
    endtask

    task automatic test_random();
        logic [1:0] mat, bresp;
        for (int n = 0; n < 30; n++) begin
            mat   = 2'($urandom);
            bresp = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            do_store($sformatf("rand%0d", n), mat, 3'($urandom), $urandom, $urandom,
                     4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), bresp, 0,
                     1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_cached();
        test_uncached();
        test_error_resp();
        test_timeout();
        test_back_to_back();
        test_ptr_zero();
        test_reset_in_baw();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, want finished", $time);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/store_drain_unit.md
STORE_DRAIN_UNIT -- requirements
Module: store_drain_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, physical address width.
REQ-002 SHALL have parameter DATA_W, default 32, store data width.
REQ-003 SHALL have parameter TMO_W, default 8, bus-response watchdog counter width.
REQ-004 SHALL have ports, one per line (name  direction  width  meaning):
 Clk  in  1  single clock, rising edge.
 Rest  in  1  reset, asynchronous, active-high.
 SbToDcdAble  in  1  store buffer has a retired store ready to drain.
 SbToDcdAMat  in  2  memory access type: 2'b01 cached, any other value uncached.
 SbToDcdAPtr  in  3  store-buffer entry index, 1..7.
 SbToDcdAPhyAddr  in  ADDR_W  physical address.
 SbToDcdAPhyDate  in  DATA_W  store data, right-aligned.
 SbToDcdAWstrb  in  4  byte strobe, address-aligned.
 DcdToSbSuccess  out  1  request accepted this cycle.
 DcdToSbBackAble  out  1  one-cycle completion pulse.
 DcdToSbBackPtr  out  3  entry index being completed.
 DcWrReq  out  1  cached write request to D-cache data port.
 DcWrAddr / DcWrData / DcWrStrb  out  ADDR_W / DATA_W / 4  cached write payload.
 DcWrAck  in  1  D-cache write done (hit, or miss refilled and written).
 BusAwValid  out  1  uncached address+data valid (AW and W presented together).
 BusAwReady  in  1  bus accepts address+data.
 BusAddr / BusWData / BusWStrb  out  ADDR_W / DATA_W / 4  uncached payload.
 BusBValid  in  1  write response valid.
 BusBReady  out  1  ready for write response.
 BusBResp  in  2  response, nonzero = error.
 DrainErr  out  1  one-cycle pulse: bus error response or watchdog expiry.

Function
REQ-005 SHALL implement FSM states IDLE, CWR, BAW, BRSP, BACK.
REQ-006 DcdToSbSuccess SHALL be combinational: SbToDcdAble AND state==IDLE. It SHALL be 0 in every other state.
REQ-007 On the Success edge the unit SHALL latch ptr, MAT, address, data and strobe. Outputs SHALL be driven only from the latched copy.
REQ-008 IDLE->CWR when accepted with MAT==2'b01. IDLE->BAW when accepted with any other MAT.
REQ-009 In CWR, DcWrReq SHALL be 1 and the payload SHALL be held stable until DcWrAck. On the DcWrAck cycle the FSM SHALL go to BACK.
REQ-010 In BAW, BusAwValid SHALL be 1 and the payload SHALL be held stable until BusAwReady. BAW->BRSP on the BusAwReady cycle.
REQ-011 In BRSP, BusBReady SHALL be 1. BRSP->BACK on BusBValid. DrainErr SHALL pulse in the same cycle if BusBResp!=0.
REQ-012 Watchdog: a TMO_W-bit counter SHALL clear on entering BRSP and increment each BRSP cycle without BusBValid. On reaching all-ones it SHALL force BRSP->BACK and pulse DrainErr.
REQ-013 BACK SHALL last exactly one cycle with DcdToSbBackAble=1 and DcdToSbBackPtr = latched ptr, then go to IDLE. No acceptance in BACK.
REQ-014 At most one store SHALL be outstanding. Minimum accept-to-accept spacing SHALL be 3 cycles (IDLE, CWR with same-cycle ack, BACK).
REQ-015 Completion order SHALL equal acceptance order. A single outstanding store guarantees this.
REQ-016 Outside their active states, DcWrReq, BusAwValid, BusBReady, DcdToSbBackAble and DrainErr SHALL be 0, and DcdToSbBackPtr SHALL be 3'd0.
REQ-017 Ack, ready and valid inputs arriving in a state that does not expect them SHALL be ignored.
REQ-018 A request whose SbToDcdAPtr==0 while SbToDcdAble=1 SHALL still be accepted. Ptr 0 is passed through on BackPtr unchanged.

Reset
REQ-019 Rest high SHALL asynchronously force state=IDLE, watchdog=0 and all latched fields=0, so every output reads 0.
REQ-020 Rest mid-transaction SHALL abandon the store without a BackAble pulse. Bus-side recovery is the bus owner's responsibility.

Structure
REQ-021 The shared package SHALL hold the FSM state encoding, the MAT encodings (MAT_SUC=2'b00, MAT_CC=2'b01) and the bus response encodings.
REQ-022 The watchdog SHALL be one sub-module, drain_watchdog (clear, enable, expire). Everything else SHALL be flat.

Verification
REQ-023 Cached: Able=1, MAT=01, Ptr=3, Addr=0x1000_0040, Data=0xDEAD_BEEF, Wstrb=F, DcWrAck 2 cycles later -> Success in cycle 0; DcWrReq in cycles 1-2; BackAble=1 with BackPtr=3 in cycle 3.
REQ-024 Uncached: MAT=00, Ptr=5, BusAwReady held 0 for 4 cycles, BValid with BResp=0 one cycle after ready -> payload stable throughout; BackPtr=5; DrainErr=0.
REQ-025 Error response: uncached, BResp=2'b10 -> DrainErr and BackAble both pulse; FSM returns to IDLE.
REQ-026 Timeout: uncached, BValid never asserted -> after 255 BRSP cycles, DrainErr=1 and BackAble=1; the next request is accepted afterward.
REQ-027 Back-to-back: Able held 1 with Ptr 1 then 2 and same-cycle DcWrAck -> Success pulses 3 cycles apart; BackPtr sequence is 1, 2.
REQ-028 Reset while in BAW -> all outputs 0 immediately, no BackAble; a fresh request after release completes normally.
